lae_seq: RTL and testbench

LAE_SEQ -- requirements
Module: lae_seq

---
 rtl/lae_pkg.sv | 17 +
 rtl/lae_rcnt.sv | 24 ++
 rtl/lae_seq.sv | 112 +++++++++++
 tb/tb_lae_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/lae_pkg.sv
// Shared types and sizing for the LAE block sequencer.
// It holds the FSM state encoding, the default round and data widths, and the block-count type.
package lae_pkg;
    localparam int ROUNDS = 16;
    localparam int DW     = 40;

    typedef logic [7:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        INIT,
        WAIT,
        PROC,
        FINAL
    } state_t;
endpackage

// File: rtl/lae_rcnt.sv
// Round counter that counts cycles within one LAE phase.
// It has a synchronous clear, a count enable and a terminal-count flag at ROUNDS-1, and wraps back to 0 after that value.
module lae_rcnt #(
    parameter int ROUNDS = 16,
    parameter int W      = 4
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);
    assign tc = (cnt == W'(ROUNDS - 1));

    always_ff @(posedge ck or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/lae_seq.sv
// LAE block sequencer: start, init rounds, then AD blocks followed by message blocks, then finalisation.
// Each absorbed block is followed by ROUNDS cycles of processing.
module lae_seq
    import lae_pkg::*;
#(
    parameter int ROUNDS = lae_pkg::ROUNDS,
    parameter int DW     = lae_pkg::DW
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          go,
    input  logic [7:0]    ad_blocks,
    input  logic [7:0]    msg_blocks,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [DW-1:0] dout,
    output logic          start,
    output logic          Ain,
    output logic          Min,
    output logic          last,
    output logic          busy,
    output logic          done
);
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    state_t        state, state_nx;
    cnt_t          ad_cnt, msg_cnt;
    logic [RW-1:0] rnd;
    logic          tc, rclr, ren, more;

    assign more = (ad_cnt != 8'd0) || (msg_cnt != 8'd0);

    lae_rcnt #(.ROUNDS(ROUNDS), .W(RW)) u_rcnt (
        .ck  (ck),
        .rst (rst),
        .clr (rclr),
        .en  (ren),
        .cnt (rnd),
        .tc  (tc)
    );

    always_ff @(posedge ck or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        start    = 1'b0;
        Ain      = 1'b0;
        Min      = 1'b0;
        last     = 1'b0;
        done     = 1'b0;
        ren      = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE:  if (go) state_nx = START;
            START: begin
                start    = 1'b1;
                state_nx = INIT;
            end
            INIT: begin
                ren = 1'b1;
                if (tc) state_nx = more ? WAIT : FINAL;
            end
            WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // AD blocks drain first, so Ain and Min are mutually exclusive.
                    if (ad_cnt != 8'd0)       Ain = 1'b1;
                    else if (msg_cnt != 8'd0) Min = 1'b1;
                    state_nx = PROC;
                end
            end
            PROC: begin
                ren = 1'b1;
                if (tc) state_nx = more ? WAIT : FINAL;
            end
            FINAL: begin
                last = 1'b1;
                ren  = 1'b1;
                if (tc) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // The round counter restarts from zero on every state change.
        rclr = (state_nx != state);
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            ad_cnt  <= '0;
            msg_cnt <= '0;
            dout    <= '0;
        end else begin
            if (state == IDLE && go) begin
                ad_cnt  <= ad_blocks;
                msg_cnt <= msg_blocks;
            end
            if (Ain) ad_cnt  <= ad_cnt - 8'd1;
            if (Min) msg_cnt <= msg_cnt - 8'd1;
            if (Ain || Min) dout <= in_data;
        end
    end
endmodule

// File: tb/tb_lae_seq.sv
// Directed bench for lae_seq: cycle-accurate phase timing, back-pressure, ignored go, reset abort, max counts.
module tb_lae_seq;
    logic        ck = 1'b0;
    logic        rst, go, in_valid;
    logic [7:0]  ad_blocks, msg_blocks;
    logic [39:0] in_data, dout;
    logic        in_ready, start, Ain, Min, last, busy, done;

    int checks = 0;
    int errors = 0;

    int c, start_cnt, start_cyc, ain_cnt, ain_cyc, min_cnt, min_cyc;
    int last_cnt, last_first, last_lastc, done_cnt, done_cyc, rdy_cnt, both, order_err;
    logic busy_after;

    lae_seq dut (
        .ck(ck), .rst(rst), .go(go), .ad_blocks(ad_blocks), .msg_blocks(msg_blocks),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .dout(dout),
        .start(start), .Ain(Ain), .Min(Min), .last(last), .busy(busy), .done(done)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_rec();
        c = 0; start_cnt = 0; start_cyc = -1; ain_cnt = 0; ain_cyc = -1;
        min_cnt = 0; min_cyc = -1; last_cnt = 0; last_first = -1; last_lastc = -1;
        done_cnt = 0; done_cyc = -1; rdy_cnt = 0; both = 0; order_err = 0; busy_after = 1'bx;
    endtask

    // Sample the current cycle mid-period, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge ck);
        if (start) begin start_cnt++; start_cyc = c; end
        if (Ain) begin ain_cnt++; if (ain_cyc < 0) ain_cyc = c; if (min_cnt > 0) order_err++; end
        if (Min) begin min_cnt++; if (min_cyc < 0) min_cyc = c; end
        if (Ain && Min) both++;
        if (last) begin last_cnt++; if (last_first < 0) last_first = c; last_lastc = c; end
        if (done_cnt > 0 && c == done_cyc + 1) busy_after = busy;
        if (done) begin done_cnt++; done_cyc = c; end
        if (in_ready) rdy_cnt++;
        c++;
        @(posedge ck);
        #1;
    endtask

    task automatic run(input int max);
        while (done_cnt == 0 && c < max) tick();
        tick();
    endtask

    task automatic launch(input logic [7:0] ad, input logic [7:0] msg);
        clr_rec();
        ad_blocks = ad; msg_blocks = msg; go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = '0;
        ad_blocks = '0; msg_blocks = '0;
        repeat (2) @(posedge ck);
        #1;
        chk("rst_outs", {in_ready, start, Ain, Min, last, busy, done}, 7'd0);
        chk("rst_dout", dout, 40'd0);
        rst = 1'b0;
        @(posedge ck);
        #1;

        // 1 AD + 1 message block with upstream always valid
        in_valid = 1'b1; in_data = 40'hA5_1234_5678;
        launch(8'd1, 8'd1);
        run(200);
        chk("t1_start_cyc", start_cyc, 1);
        chk("t1_ain_cyc", ain_cyc, 18);
        chk("t1_min_cyc", min_cyc, 35);
        chk("t1_last_first", last_first, 52);
        chk("t1_last_end", last_lastc, 67);
        chk("t1_last_cnt", last_cnt, 16);
        chk("t1_done_cyc", done_cyc, 67);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_busy_after", busy_after, 0);
        chk("t1_dout", dout, 40'hA5_1234_5678);

        // Empty operation: straight from INIT to FINAL
        launch(8'd0, 8'd0);
        run(200);
        chk("t2_start_cyc", start_cyc, 1);
        chk("t2_last_first", last_first, 18);
        chk("t2_last_cnt", last_cnt, 16);
        chk("t2_done_cyc", done_cyc, 33);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_rdy_cnt", rdy_cnt, 0);
        chk("t2_blocks", ain_cnt + min_cnt, 0);

        // Two AD blocks, upstream stalls for 5 cycles in the first WAIT
        in_valid = 1'b0; in_data = 40'h11_2233_4455;
        launch(8'd2, 8'd0);
        while (rdy_cnt == 0 && c < 100) tick();
        repeat (4) tick();
        chk("t3_stall_rdy", rdy_cnt, 5);
        chk("t3_stall_ain", ain_cnt, 0);
        chk("t3_stall_state", in_ready, 1);
        in_valid = 1'b1;
        tick();
        chk("t3_ain1", ain_cnt, 1);
        chk("t3_dout1", dout, 40'h11_2233_4455);
        in_data = 40'hCC_DDEE_FF00;
        repeat (3) tick();
        chk("t3_dout_hold", dout, 40'h11_2233_4455);
        run(200);
        chk("t3_ain_cnt", ain_cnt, 2);
        chk("t3_min_cnt", min_cnt, 0);
        chk("t3_dout2", dout, 40'hCC_DDEE_FF00);
        chk("t3_done_cnt", done_cnt, 1);

        // go during PROC must be ignored
        launch(8'd1, 8'd1);
        while (ain_cnt == 0 && c < 100) tick();
        repeat (3) tick();
        go = 1'b1; ad_blocks = 8'd5; msg_blocks = 8'd5;
        tick();
        go = 1'b0;
        run(300);
        chk("t4_start_cnt", start_cnt, 1);
        chk("t4_blocks", {ain_cnt[15:0], min_cnt[15:0]}, {16'd1, 16'd1});
        chk("t4_done_cyc", done_cyc, 67);
        chk("t4_done_cnt", done_cnt, 1);

        // Reset during FINAL at round 7, then a clean restart
        launch(8'd0, 8'd0);
        while (last_cnt == 0 && c < 100) tick();
        repeat (6) tick();
        chk("t5_pre_last", last, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_outs", {in_ready, start, Ain, Min, last, busy, done}, 7'd0);
        chk("t5_rst_dout", dout, 40'd0);
        repeat (3) tick();
        chk("t5_no_done", done_cnt, 0);
        rst = 1'b0;
        in_data = 40'h0F_0F0F_0F0F;
        launch(8'd0, 8'd1);
        run(200);
        chk("t5_min_cyc", min_cyc, 18);
        chk("t5_min_cnt", min_cnt, 1);
        chk("t5_ain_cnt", ain_cnt, 0);
        chk("t5_done_cyc", done_cyc, 50);
        chk("t5_done_cnt", done_cnt, 1);

        // Maximum block counts
        launch(8'd255, 8'd255);
        run(12000);
        chk("t6_ain_cnt", ain_cnt, 255);
        chk("t6_min_cnt", min_cnt, 255);
        chk("t6_order", order_err, 0);
        chk("t6_both", both, 0);
        chk("t6_done_cyc", done_cyc, 8703);
        chk("t6_done_cnt", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
